router_ctrl: RTL and testbench

- Ingress controller for the 1x3 packet router. It sits between the write-side source (data_in/pkt_valid/busy/error) and the three output FIFOs.
- Decodes the header, steers every byte of a packet to one FIFO and stalls the source with busy.
- Checks length and parity, and generates per-port soft resets when a non-empty FIFO goes unread too long.

---
 rtl/router_ctrl.sv | 159 +++++++++++++++
 tb/tb_router_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ctrl.sv
// rtl/router_ctrl.sv - 1x3 router ingress control: header decode, FIFO steering, parity/length check, timeouts
// Optional feature macro: ROUTER_TIMEOUT_EN (per-port unread timers and soft_reset abort path)
module router_ctrl #(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int TMR_W          = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic       error,
  output logic [2:0] write_enb,
  output logic [7:0] fifo_wdata,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    IDLE, WAIT_EMPTY, WRITE_HDR, LOAD_DATA, CHECK_PARITY, DROP
  } state_t;

  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] header_reg;
  logic [7:0] parity_acc;
  logic [7:0] rx_parity;
  logic [5:0] byte_cnt;

  logic [2:0] dest_onehot;
  logic [2:0] in_onehot;
  logic       dest_full;
  logic       in_empty;
  logic       abort;

  assign dest_onehot = 3'b001 << header_reg[1:0];
  assign in_onehot   = 3'b001 << data_in[1:0];
  assign dest_full   = |(fifo_full & dest_onehot);
  assign in_empty    = |(fifo_empty & in_onehot);

`ifdef ROUTER_TIMEOUT_EN
  logic [TMR_W-1:0] timer [3];

  assign abort = |(soft_reset & dest_onehot);

  // A port's timer only runs while its FIFO holds data nobody is reading.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      soft_reset <= 3'b000;
      for (int i = 0; i < 3; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        soft_reset[i] <= 1'b0;
        if (fifo_empty[i] || read_enb[i] || soft_reset[i]) begin
          timer[i] <= '0;
        end else if (timer[i] == TMR_MAX) begin
          timer[i]      <= '0;
          soft_reset[i] <= 1'b1;
        end else begin
          timer[i] <= timer[i] + TMR_W'(1);
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign abort      = 1'b0;
  assign soft_reset = 3'b000;
  assign unused_cfg = ^{read_enb, TMR_MAX};
`endif

  always_comb begin
    busy       = 1'b0;
    write_enb  = 3'b000;
    fifo_wdata = data_in;
    case (state)
      WAIT_EMPTY, CHECK_PARITY: busy = 1'b1;
      WRITE_HDR: begin
        busy       = 1'b1;
        fifo_wdata = header_reg;
        if (!abort) write_enb = dest_onehot;
      end
      LOAD_DATA: begin
        busy = dest_full;
        if (!dest_full && !abort) write_enb = dest_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      error      <= 1'b0;
      header_reg <= 8'h00;
      parity_acc <= 8'h00;
      rx_parity  <= 8'h00;
      byte_cnt   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_valid) begin
            header_reg <= data_in;
            parity_acc <= data_in;
            byte_cnt   <= 6'd0;
            error      <= (data_in[1:0] == 2'd3);
            if (data_in[1:0] == 2'd3) state <= DROP;
            else if (!in_empty)       state <= WAIT_EMPTY;
            else                      state <= WRITE_HDR;
          end
        end
        WAIT_EMPTY: begin
          if (abort) begin
            error <= 1'b1;
            state <= DROP;
          end else if (|(fifo_empty & dest_onehot)) begin
            state <= WRITE_HDR;
          end
        end
        WRITE_HDR: begin
          if (abort) begin
            error <= 1'b1;
            state <= DROP;
          end else begin
            state <= LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (abort) begin
            error <= 1'b1;
            state <= DROP;
          end else if (!dest_full) begin
            // pkt_valid low marks the parity byte, which is written like payload.
            if (pkt_valid) begin
              parity_acc <= parity_acc ^ data_in;
              if (byte_cnt != 6'd63) byte_cnt <= byte_cnt + 6'd1;
            end else begin
              rx_parity <= data_in;
              state     <= CHECK_PARITY;
            end
          end
        end
        CHECK_PARITY: begin
          if (rx_parity != parity_acc || byte_cnt != header_reg[7:2]) error <= 1'b1;
          state <= IDLE;
        end
        DROP: begin
          if (!pkt_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// tb/tb_router_ctrl.sv - directed self-checking bench for router_ctrl
module tb_router_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] read_enb = 3'b000;
  logic       busy;
  logic       error;
  logic [2:0] write_enb;
  logic [7:0] fifo_wdata;
  logic [2:0] soft_reset;

  router_ctrl #(.TIMEOUT_CYCLES(30), .TMR_W(5)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .busy(busy), .error(error), .write_enb(write_enb), .fifo_wdata(fifo_wdata),
    .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_cycles = 0;
  int          full_cnt = 0;
  int          full_idx = -1;
  logic [2:0]  full_mask = 3'b000;
  logic [10:0] wr_log[$];
  logic [10:0] exp_q[$];
  logic [7:0]  pkt_q[$];

  always @(negedge clock) begin
    if (busy === 1'b1) busy_cycles++;
    if (write_enb !== 3'b000) wr_log.push_back({write_enb, fifo_wdata});
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (full_cnt > 0) begin
      full_cnt--;
      if (full_cnt == 0) fifo_full = 3'b000;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pv);
    logic acc;
    acc = 1'b0;
    data_in = b;
    pkt_valid = pv;
    for (int n = 0; n < 60 && !acc; n++) begin
      @(negedge clock);
      acc = (busy === 1'b0);
      step();
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_byte: byte %h not accepted in 60 cycles, busy=%b required 0", b, busy);
    end
  endtask

  task automatic send_packet();
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_byte(pkt_q[i], (i != pkt_q.size() - 1));
      if (i == full_idx) begin
        fifo_full = full_mask;
        full_cnt  = 4;
      end
    end
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++;
    if ({busy, error, write_enb, soft_reset} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: busy/error/write_enb/soft_reset=%b required 00000000",
               {busy, error, write_enb, soft_reset});
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || write_enb !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b write_enb=%b required 0/000", busy, write_enb);
    end
  endtask

  task automatic test_good_packet();
    wr_log.delete();
    busy_cycles = 0;
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    exp_q = '{{3'b010, 8'h0D}, {3'b010, 8'h11}, {3'b010, 8'h22}, {3'b010, 8'h33}, {3'b010, 8'h0D}};
    send_packet();
    n_checks++;
    if (wr_log.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL good_count: writes=%0d required %0d", wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL good_write[%0d]: got %h required %h", i, wr_log[i], exp_q[i]);
      end
    end
    n_checks++;
    if (busy_cycles != 2) begin
      n_fail++;
      $display("FAIL good_busy: busy cycles=%0d required 2", busy_cycles);
    end
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL good_error: error=%b required 0", error);
    end
  endtask

  task automatic test_bad_parity();
    wr_log.delete();
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    send_packet();
    n_checks++;
    if (wr_log.size() != 5 || wr_log[4] !== {3'b010, 8'h00}) begin
      n_fail++;
      $display("FAIL parity_writes: count=%0d required 5 with last 200", wr_log.size());
    end
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_error: error=%b required 1", error);
    end
    repeat (3) step();
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_error_hold: error=%b required 1", error);
    end
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_packet();
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_error_clear: error=%b required 0", error);
    end
  endtask

  task automatic test_length_error();
    wr_log.delete();
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h3E};
    send_packet();
    n_checks++;
    if (wr_log.size() != 4) begin
      n_fail++;
      $display("FAIL len_writes: count=%0d required 4", wr_log.size());
    end
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL len_error: error=%b required 1", error);
    end
  endtask

  task automatic test_bad_addr();
    wr_log.delete();
    busy_cycles = 0;
    pkt_q = '{8'h07, 8'h55, 8'h52};
    send_packet();
    n_checks++;
    if (wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL addr3_writes: count=%0d required 0", wr_log.size());
    end
    n_checks++;
    if (busy_cycles != 0) begin
      n_fail++;
      $display("FAIL addr3_busy: busy cycles=%0d required 0", busy_cycles);
    end
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL addr3_error: error=%b required 1", error);
    end
  endtask

  task automatic test_full_stall();
    wr_log.delete();
    busy_cycles = 0;
    full_idx  = 2;
    full_mask = 3'b100;
    pkt_q = '{8'h0E, 8'hA1, 8'hB2, 8'hC3, 8'hDE};
    exp_q = '{{3'b100, 8'h0E}, {3'b100, 8'hA1}, {3'b100, 8'hB2}, {3'b100, 8'hC3}, {3'b100, 8'hDE}};
    send_packet();
    full_idx = -1;
    n_checks++;
    if (wr_log.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_count: writes=%0d required %0d", wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_write[%0d]: got %h required %h", i, wr_log[i], exp_q[i]);
      end
    end
    n_checks++;
    if (busy_cycles != 6) begin
      n_fail++;
      $display("FAIL full_busy: busy cycles=%0d required 6", busy_cycles);
    end
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL full_error: error=%b required 0", error);
    end
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    int others;
    int exp_first;
    int exp_pulses;
`ifdef ROUTER_TIMEOUT_EN
    exp_first  = 30;
    exp_pulses = 1;
`else
    exp_first  = -1;
    exp_pulses = 0;
`endif
    first = -1;
    pulses = 0;
    others = 0;
    fifo_empty = 3'b110;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (soft_reset[0] === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (soft_reset[2:1] !== 2'b00) others++;
    end
    n_checks++;
    if (first != exp_first || pulses != exp_pulses) begin
      n_fail++;
      $display("FAIL timeout_pulse: first=%0d pulses=%0d required %0d/%0d", first, pulses, exp_first, exp_pulses);
    end
    fifo_empty = 3'b111;
    step();
    step();
    pulses = 0;
    fifo_empty = 3'b110;
    for (int k = 1; k <= 35; k++) begin
      if (k == 29) read_enb = 3'b001;
      if (k == 30) read_enb = 3'b000;
      step();
      if (soft_reset[0] === 1'b1) pulses++;
      if (soft_reset[2:1] !== 2'b00) others++;
    end
    fifo_empty = 3'b111;
    step();
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL timeout_read_clear: pulses=%0d required 0", pulses);
    end
    n_checks++;
    if (others != 0) begin
      n_fail++;
      $display("FAIL timeout_other_ports: pulses=%0d required 0", others);
    end
  endtask

`ifdef ROUTER_TIMEOUT_EN
  task automatic test_timeout_abort();
    wr_log.delete();
    fifo_empty = 3'b110;
    pkt_q = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h0C};
    send_packet();
    fifo_empty = 3'b111;
    step();
    n_checks++;
    if (wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL abort_writes: count=%0d required 0", wr_log.size());
    end
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_error: error=%b busy=%b required 1/0", error, busy);
    end
  endtask
`endif

  task automatic test_reset_midpacket();
    send_byte(8'h0D, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    data_in = 8'h33;
    pkt_valid = 1'b1;
    #1;
    n_checks++;
    if (write_enb !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_write: write_enb=%b required 010", write_enb);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, error, write_enb} !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_reset: busy/error/write_enb=%b required 00000", {busy, error, write_enb});
    end
    pkt_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    wr_log.delete();
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_packet();
    n_checks++;
    if (wr_log.size() != 5 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_restart: writes=%0d error=%b required 5/0", wr_log.size(), error);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_length_error();
    test_bad_addr();
    test_full_stall();
    test_timeout();
`ifdef ROUTER_TIMEOUT_EN
    test_timeout_abort();
`endif
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
